ro_freq_counter: RTL and testbench

//   Measures the ring-oscillator output frequency in units of clk cycles. It sits directly

---
 rtl/ro_pkg.sv | 14 +
 rtl/ro_sync2.sv | 28 ++
 rtl/ro_freq_counter.sv | 137 +++++++++++++
 tb/tb_ro_freq_counter.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/ro_pkg.sv
// Shared definitions for the ring-oscillator measurement blocks.
// The state enum is also used by the tt_um_ro wrapper for output muxing.
package ro_pkg;

    localparam int unsigned GATE_W_DEF = 16;
    localparam int unsigned CNT_W_DEF  = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        DONE    = 2'd2
    } ro_state_e;

endpackage

// File: rtl/ro_sync2.sv
// Two-flop synchronizer with synchronous active-high reset.
// Generic width so it can be reused for any asynchronous input.
module ro_sync2 #(
    parameter int unsigned W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] s1_q;
    logic [W-1:0] s2_q;

    // Metastability chain: d_i -> s1 -> s2.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= d_i;
            s2_q <= s1_q;
        end
    end

    assign q_o = s2_q;

endmodule

// File: rtl/ro_freq_counter.sv
// Ring-oscillator frequency counter: counts synchronized RO rising edges
// over a programmable window of clk cycles and holds the result.
module ro_freq_counter
    import ro_pkg::*;
#(
    parameter int unsigned GATE_W = GATE_W_DEF,
    parameter int unsigned CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ro_in,
    input  logic              start,
    input  logic              abort,
    input  logic [GATE_W-1:0] gate_len,
    output logic              busy,
    output logic              done,
    output logic              valid,
    output logic [CNT_W-1:0]  count,
    output logic              ovf
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic              ro_s2;
    logic              s3_q;
    logic              ro_edge;

    ro_state_e         state_q,    state_d;
    logic [GATE_W-1:0] gate_cnt_q, gate_cnt_d;
    logic [CNT_W-1:0]  edge_cnt_q, edge_cnt_d;
    logic [CNT_W-1:0]  count_q,    count_d;
    logic              ovf_q,      ovf_d;
    logic              valid_q,    valid_d;
    logic              done_q,     done_d;

    ro_sync2 #(.W(1)) u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (ro_in),
        .q_o (ro_s2)
    );

    // Edge flop; runs in every state so no flush is needed on start.
    always_ff @(posedge clk) begin
        if (rst) begin
            s3_q <= 1'b0;
        end else begin
            s3_q <= ro_s2;
        end
    end

    assign ro_edge = ro_s2 & ~s3_q;

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            gate_cnt_q <= '0;
            edge_cnt_q <= '0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
            valid_q    <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            gate_cnt_q <= gate_cnt_d;
            edge_cnt_q <= edge_cnt_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
            valid_q    <= valid_d;
            done_q     <= done_d;
        end
    end

    // Next-state logic: start/abort handling, window countdown, saturating count.
    always_comb begin
        state_d    = state_q;
        gate_cnt_d = gate_cnt_q;
        edge_cnt_d = edge_cnt_q;
        count_d    = count_q;
        ovf_d      = ovf_q;
        valid_d    = valid_q;
        done_d     = 1'b0;

        unique case (state_q)
            IDLE, DONE: begin
                // Start wins over a simultaneous abort here.
                if (start) begin
                    ovf_d = 1'b0;
                    if (gate_len != '0) begin
                        gate_cnt_d = gate_len;
                        edge_cnt_d = '0;
                        valid_d    = 1'b0;
                        state_d    = MEASURE;
                    end else begin
                        count_d = '0;
                        valid_d = 1'b1;
                        done_d  = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            MEASURE: begin
                if (abort) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end else begin
                    if (ro_edge) begin
                        if (edge_cnt_q == CNT_MAX) begin
                            ovf_d = 1'b1;
                        end else begin
                            edge_cnt_d = edge_cnt_q + CNT_W'(1);
                        end
                    end
                    gate_cnt_d = gate_cnt_q - GATE_W'(1);
                    // Last window cycle: its own edge is already folded into edge_cnt_d.
                    if (gate_cnt_q == GATE_W'(1)) begin
                        count_d = edge_cnt_d;
                        valid_d = 1'b1;
                        done_d  = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy  = (state_q == MEASURE);
    assign done  = done_q;
    assign valid = valid_q;
    assign count = count_q;
    assign ovf   = ovf_q;

endmodule

// File: tb/tb_ro_freq_counter.sv
// Directed bench for ro_freq_counter with a result scoreboard.
module tb_ro_freq_counter;

    logic        clk = 1'b0;
    logic        rst;
    logic        ro_in = 1'b0;
    logic        start;
    logic        abort;
    logic [15:0] gate_len;
    logic        busy;
    logic        done;
    logic        valid;
    logic [3:0]  count;
    logic        ovf;

    int unsigned n_pass  = 0;
    int unsigned n_total = 0;

    int unsigned ro_per = 10;
    int unsigned ro_ph  = 0;

    typedef struct {
        string       tag;
        int unsigned count;
        int unsigned ovf;
        int unsigned lat;
    } exp_t;

    exp_t sb[$];

    ro_freq_counter #(.GATE_W(16), .CNT_W(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .ro_in    (ro_in),
        .start    (start),
        .abort    (abort),
        .gate_len (gate_len),
        .busy     (busy),
        .done     (done),
        .valid    (valid),
        .count    (count),
        .ovf      (ovf)
    );

    always #5 clk = ~clk;

    // Free-running square wave, changed away from the clock edge.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            ro_ph = (ro_ph + 1) % ro_per;
            ro_in = (ro_ph < ro_per / 2);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic push_exp(input string tag, input int unsigned c, input int unsigned o, input int unsigned lat);
        exp_t e;
        e.tag = tag; e.count = c; e.ovf = o; e.lat = lat;
        sb.push_back(e);
    endtask

    // Called right after the tick that sampled start; waits for done and scores it.
    task automatic wait_result(input int unsigned budget);
        exp_t        e;
        int unsigned n;
        bit          got;
        n = 0;
        got = 1'b0;
        while (n <= budget) begin
            if (done === 1'b1) begin
                got = 1'b1;
                break;
            end
            tick();
            n++;
        end
        if (sb.size() == 0) begin
            check("sb_underflow", 32'd1, 32'd0);
            return;
        end
        e = sb.pop_front();
        check({e.tag, "_done_seen"}, 32'(got), 32'd1);
        if (got) begin
            check({e.tag, "_latency"}, n, e.lat);
            check({e.tag, "_count"}, 32'(count), e.count);
            check({e.tag, "_ovf"}, 32'(ovf), e.ovf);
            check({e.tag, "_valid"}, 32'(valid), 32'd1);
            check({e.tag, "_busy"}, 32'(busy), 32'd0);
            tick();
            check({e.tag, "_done_pulse"}, 32'(done), 32'd0);
            check({e.tag, "_count_hold"}, 32'(count), e.count);
            check({e.tag, "_valid_hold"}, 32'(valid), 32'd1);
        end
    endtask

    initial begin
        bit seen;

        rst = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        gate_len = '0;

        // 1. reset defaults
        repeat (3) tick();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        rst = 1'b0;
        repeat (20) tick();

        // 4. zero gate: immediate result, never busy
        gate_len = 16'd0;
        start = 1'b1;
        push_exp("zero", 0, 0, 0);
        tick();
        start = 1'b0;
        check("zero_busy", 32'(busy), 32'd0);
        wait_result(5);

        // 2. basic count: period 10, window 100 -> 10 edges
        gate_len = 16'd100;
        start = 1'b1;
        push_exp("basic", 10, 0, 100);
        tick();
        start = 1'b0;
        check("basic_busy", 32'(busy), 32'd1);
        check("basic_valid_clr", 32'(valid), 32'd0);
        wait_result(110);

        // 3. saturation: period 4, window 64 -> 16 edges into a 4-bit counter
        ro_per = 4;
        repeat (12) tick();
        gate_len = 16'd64;
        start = 1'b1;
        push_exp("sat", 15, 1, 64);
        tick();
        start = 1'b0;
        check("sat_ovf_clr", 32'(ovf), 32'd0);
        wait_result(80);

        // 5. re-start ignored, then abort
        gate_len = 16'd50;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("abrt_busy", 32'(busy), 32'd1);
        check("abrt_valid_clr", 32'(valid), 32'd0);
        repeat (9) tick();
        gate_len = 16'd5;
        start = 1'b1;
        tick();
        start = 1'b0;
        gate_len = 16'd50;
        check("restart_ignored_busy", 32'(busy), 32'd1);
        repeat (9) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abrt_idle", 32'(busy), 32'd0);
        check("abrt_valid", 32'(valid), 32'd0);
        check("abrt_count_kept", 32'(count), 32'd15);
        seen = 1'b0;
        repeat (60) begin
            tick();
            if (done === 1'b1 || busy === 1'b1) seen = 1'b1;
        end
        check("abrt_no_done", 32'(seen), 32'd0);

        // abort in IDLE does nothing
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("idle_abort_busy", 32'(busy), 32'd0);
        check("idle_abort_count", 32'(count), 32'd15);

        // abort on the final window cycle beats completion
        gate_len = 16'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("lastcyc_abort_done", 32'(done), 32'd0);
        check("lastcyc_abort_busy", 32'(busy), 32'd0);
        check("lastcyc_abort_valid", 32'(valid), 32'd0);
        tick();
        check("lastcyc_abort_done2", 32'(done), 32'd0);

        // 6. start+abort together (start wins), then reset mid-window
        gate_len = 16'd100;
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        check("start_wins_busy", 32'(busy), 32'd1);
        repeat (29) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_valid", 32'(valid), 32'd0);
        check("midrst_count", 32'(count), 32'd0);
        check("midrst_ovf", 32'(ovf), 32'd0);
        seen = 1'b0;
        repeat (120) begin
            tick();
            if (done === 1'b1) seen = 1'b1;
        end
        check("midrst_no_done", 32'(seen), 32'd0);

        check("sb_empty", sb.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
